// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types, constants and decode helpers for the load/store
//            unit (FSM states, RV32I load/store funct3 codes).
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  // RV32I load/store size/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know B/H/W; loads additionally know the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  // Halfwords need even addresses, words need 4-byte aligned addresses.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (f3[1:0] == 2'b01) begin
      bad = lo[0];
    end else if (f3[1:0] == 2'b10) begin
      bad = (lo != 2'b00);
    end
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : Combinational byte/half lane select plus sign or zero extension
//            of a bus read word into the load result.
// Revision : 1.0 - initial release
// ============================================================================
module load_extend
  import lsu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] rdata,
  input  logic [1:0]   addr_lo,
  input  logic [2:0]   funct3,
  output logic [W-1:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte and halfword lanes out of the read word
  always_comb begin
    lane_b = rdata[7:0];
    case (addr_lo)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected lane according to the access size/sign code
  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{(W-8){lane_b[7]}}, lane_b};
      F3_H:    result = {{(W-16){lane_h[15]}}, lane_h};
      F3_BU:   result = {{(W-8){1'b0}}, lane_b};
      F3_HU:   result = {{(W-16){1'b0}}, lane_h};
      default: result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Single-outstanding load/store unit between the execute stage and
//            a request/grant bus with separate read-valid response. Handles
//            alignment/funct3 checking, byte enables, lane replication, load
//            extension and a bus-response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int W       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_req,
  input  logic         mem_we,
  input  logic [2:0]   funct3,
  input  logic [W-1:0] addr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] ReadData,
  output logic         done,
  output logic         stall,
  output logic         access_err,
  output logic         bus_req,
  output logic         bus_we,
  output logic [W-1:0] bus_addr,
  output logic [3:0]   bus_be,
  output logic [W-1:0] bus_wdata,
  input  logic         bus_gnt,
  input  logic         bus_rvalid,
  input  logic [W-1:0] bus_rdata
);

  // Last counter value at which a missing gnt/rvalid is declared a timeout
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_t   state;
  logic         we_q;
  logic [2:0]   f3_q;
  logic [W-1:0] addr_q;
  logic [W-1:0] wdata_q;
  logic [7:0]   cnt;
  logic         err_q;
  logic [W-1:0] rd_q;

  logic         req_ok;
  logic         accept;
  logic         reject;
  logic         timed_out;
  logic [W-1:0] load_val;

  // Decode the incoming request while idle
  always_comb begin
    req_ok    = f3_legal(mem_we, funct3) && !misaligned(funct3, addr[1:0]);
    accept    = (state == IDLE) && mem_req && req_ok;
    reject    = (state == IDLE) && mem_req && !req_ok;
    // Counter spans REQ and WAIT together, so >= keeps WAIT covered after
    // a grant that arrived on the very last REQ cycle.
    timed_out = (cnt >= TO_LAST);
  end

  load_extend #(.W(W)) u_load_extend (
    .rdata   (bus_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .result  (load_val)
  );

  // Access FSM: latches the request, tracks the bus handshake and timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= 8'd0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (accept) begin
            we_q    <= mem_we;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= 8'd0;
            state   <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (bus_gnt) begin
            state <= we_q ? DONE : WAIT;
          end else if (timed_out) begin
            err_q <= 1'b1;
            state <= DONE;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (bus_rvalid) begin
            rd_q  <= load_val;
            state <= DONE;
          end else if (timed_out) begin
            err_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake/status outputs; immediate rejects complete in the request cycle
  always_comb begin
    stall      = rst_n && (accept || (state == REQ) || (state == WAIT));
    done       = rst_n && (reject || (state == DONE));
    access_err = rst_n && (reject || ((state == DONE) && err_q));
    bus_req    = rst_n && (state == REQ);
    bus_we     = rst_n && (state == REQ) && we_q;
    bus_addr   = {addr_q[W-1:2], 2'b00};
    ReadData   = rd_q;
  end

  // Byte enables and lane-replicated store data from the latched request
  always_comb begin
    bus_be    = 4'b1111;
    bus_wdata = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        bus_be    = 4'b0001 << addr_q[1:0];
        bus_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        bus_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        bus_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        bus_be    = 4'b1111;
        bus_wdata = wdata_q;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] ReadData;
  logic        done;
  logic        stall;
  logic        access_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.W(32), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .ReadData   (ReadData),
    .done       (done),
    .stall      (stall),
    .access_err (access_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the input-drive point of the next cycle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait load; returns at the falling edge of the DONE cycle
  task automatic do_load(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    mem_req = 1'b1; mem_we = 1'b0; funct3 = f; addr = a;
    cyc();
    mem_req = 1'b0; bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = d;
    cyc();
    bus_rvalid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

    // ---- reset state
    cyc(); cyc();
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_busreq", bus_req, 0);
    chk("rst_err", access_err, 0);
    chk("rst_rdata", ReadData, 32'h0);
    cyc();
    rst_n = 1'b1;

    // ---- LB addr 0x103, immediate gnt/rvalid
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b000; addr = 32'h103;
    @(negedge clk);
    chk("lb_c0_stall", stall, 1);
    chk("lb_c0_done", done, 0);
    cyc();
    mem_req = 1'b0; bus_gnt = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_DEAD;  // rvalid in REQ must be ignored
    @(negedge clk);
    chk("lb_c1_busreq", bus_req, 1);
    chk("lb_c1_addr", bus_addr, 32'h100);
    chk("lb_c1_stall", stall, 1);
    cyc();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h80FF_FF00;
    @(negedge clk);
    chk("lb_c2_stall", stall, 1);
    chk("lb_c2_busreq", bus_req, 0);
    chk("lb_c2_done", done, 0);
    cyc();
    bus_rvalid = 1'b0;
    mem_req = 1'b1; funct3 = 3'b010; addr = 32'h1;  // ignored in DONE
    @(negedge clk);
    chk("lb_c3_done", done, 1);
    chk("lb_c3_stall", stall, 0);
    chk("lb_c3_err", access_err, 0);
    chk("lb_rdata", ReadData, 32'hFFFF_FF80);
    cyc();
    mem_req = 1'b0;
    @(negedge clk);
    chk("lb_c4_done", done, 0);

    // ---- SH addr 0x202
    cyc();
    mem_req = 1'b1; mem_we = 1'b1; funct3 = 3'b001; addr = 32'h202; wdata = 32'h1234_ABCD;
    @(negedge clk);
    chk("sh_c0_stall", stall, 1);
    cyc();
    mem_req = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    chk("sh_busreq", bus_req, 1);
    chk("sh_buswe", bus_we, 1);
    chk("sh_addr", bus_addr, 32'h200);
    chk("sh_be", bus_be, 4'b1100);
    chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    cyc();
    bus_gnt = 1'b0;
    @(negedge clk);
    chk("sh_done", done, 1);
    chk("sh_stall", stall, 0);
    chk("sh_rdata_kept", ReadData, 32'hFFFF_FF80);

    // ---- SB addr 0x201
    cyc();
    mem_req = 1'b1; mem_we = 1'b1; funct3 = 3'b000; addr = 32'h201; wdata = 32'h0000_005A;
    cyc();
    mem_req = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    chk("sb_be", bus_be, 4'b0010);
    chk("sb_wdata", bus_wdata, 32'h5A5A_5A5A);
    cyc();
    bus_gnt = 1'b0;
    @(negedge clk);
    chk("sb_done", done, 1);

    // ---- LW misaligned addr 0x101
    cyc();
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h101;
    @(negedge clk);
    chk("mis_err", access_err, 1);
    chk("mis_done", done, 1);
    chk("mis_stall", stall, 0);
    chk("mis_busreq", bus_req, 0);
    cyc();
    mem_req = 1'b0;
    @(negedge clk);
    chk("mis_c1_busreq", bus_req, 0);
    chk("mis_c1_done", done, 0);

    // ---- illegal store funct3 100 on aligned address
    cyc();
    mem_req = 1'b1; mem_we = 1'b1; funct3 = 3'b100; addr = 32'h40;
    @(negedge clk);
    chk("ill_err", access_err, 1);
    chk("ill_stall", stall, 0);
    cyc();
    mem_req = 1'b0;
    @(negedge clk);
    chk("ill_busreq", bus_req, 0);

    // ---- preload ReadData = 0x1111_1111, then LW timeout
    cyc();
    do_load(32'h10, 3'b010, 32'h1111_1111);
    chk("pre_rdata", ReadData, 32'h1111_1111);
    cyc();
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h20;
    @(negedge clk);
    chk("to_c0_stall", stall, 1);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      mem_req = 1'b0;
      @(negedge clk);
      chk("to_req_busreq", bus_req, 1);
      chk("to_req_done", done, 0);
    end
    cyc();
    @(negedge clk);
    chk("to_done", done, 1);
    chk("to_err", access_err, 1);
    chk("to_busreq", bus_req, 0);
    chk("to_rdata_kept", ReadData, 32'h1111_1111);

    // ---- grant on the timeout cycle wins
    cyc();
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h24;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      mem_req = 1'b0;
      bus_gnt = (i == 16);
    end
    @(negedge clk);
    chk("race_gnt_busreq", bus_req, 1);
    cyc();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h2222_2222;
    @(negedge clk);
    chk("race_wait_done", done, 0);
    chk("race_wait_stall", stall, 1);
    cyc();
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("race_done", done, 1);
    chk("race_err", access_err, 0);
    chk("race_rdata", ReadData, 32'h2222_2222);

    // ---- LHU addr 0x2, rvalid delayed
    cyc();
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b101; addr = 32'h2;
    cyc();
    mem_req = 1'b0; bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lhu_wait_stall", stall, 1);
      chk("lhu_wait_done", done, 0);
      cyc();
    end
    bus_rvalid = 1'b1; bus_rdata = 32'hBEEF_0000;
    cyc();
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("lhu_done", done, 1);
    chk("lhu_stall", stall, 0);
    chk("lhu_rdata", ReadData, 32'h0000_BEEF);

    // ---- more extension cases
    cyc();
    do_load(32'h0, 3'b001, 32'h1234_8001);
    chk("lh_rdata", ReadData, 32'hFFFF_8001);
    cyc();
    do_load(32'h1, 3'b100, 32'h0000_9F00);
    chk("lbu_rdata", ReadData, 32'h0000_009F);

    // ---- reset during WAIT
    cyc();
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h30;
    cyc();
    mem_req = 1'b0; bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0;
    #2;
    chk("rw_pre_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_stall", stall, 0);
    chk("rw_busreq", bus_req, 0);
    chk("rw_done", done, 0);
    chk("rw_rdata", ReadData, 32'h0);
    cyc();
    rst_n = 1'b1;
    do_load(32'h40, 3'b010, 32'hCAFE_F00D);
    chk("post_rst_done", done, 1);
    chk("post_rst_rdata", ReadData, 32'hCAFE_F00D);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter W, default 32, data/address width; only 32 is supported.
REQ-002 Parameter TIMEOUT, default 16, bus-response cycle limit, legal range 2..255.
REQ-003 Clock and reset: one clock, clk; reset rst_n, asynchronous, active-low.
REQ-004 clk  in  1  clock, all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 mem_req  in  1  execute stage presents a load/store this cycle.
REQ-007 mem_we  in  1  1 = store, 0 = load.
REQ-008 funct3  in  3  access size/sign code (RV32I load/store encoding).
REQ-009 addr  in  W  byte address from the ALU.
REQ-010 wdata  in  W  store data, rs2.
REQ-011 ReadData  out  W  extended load result, consumed by the writeback result select.
REQ-012 done  out  1  one-cycle pulse marking access completion.
REQ-013 stall  out  1  holds the pipeline while an access is in flight.
REQ-014 access_err  out  1  one-cycle pulse on misaligned access, illegal funct3 or timeout.
REQ-015 bus_req  out  1  bus request, held until bus_gnt.
REQ-016 bus_we  out  1  bus write enable.
REQ-017 bus_addr  out  W  word address, addr with bits [1:0] forced to 0.
REQ-018 bus_be  out  4  byte enables.
REQ-019 bus_wdata  out  W  lane-replicated store data.
REQ-020 bus_gnt  in  1  bus accepted the request.
REQ-021 bus_rvalid  in  1  read data valid.
REQ-022 bus_rdata  in  W  read data word.

Function
REQ-023 The FSM SHALL use states IDLE, REQ, WAIT and DONE.
REQ-024 IDLE, accept (mem_req, legal, aligned): latch we/funct3/addr/wdata; go to REQ; stall=1 in that cycle.
REQ-025 IDLE, mem_req with misalignment or illegal funct3: access_err=1 and done=1 in the same cycle; stall=0; no bus request; stay in IDLE.
REQ-026 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0. Illegal funct3: loads 011/110/111; stores any code other than 000/001/010.
REQ-027 REQ: bus_req=1 and stall=1. On bus_gnt: store goes to DONE; load goes to WAIT.
REQ-028 WAIT: bus_req=0 and stall=1. On bus_rvalid, capture the extended bus_rdata into ReadData and go to DONE.
REQ-029 DONE: done=1 and stall=0; mem_req is ignored; return to IDLE next cycle.
REQ-030 Minimum latency: load 3 cycles accept-to-DONE with zero-wait gnt/rvalid; store 2 cycles.
REQ-031 Timeout counter: clear on accept; increment each cycle in REQ/WAIT.
REQ-032 Timeout: on reaching TIMEOUT without gnt or rvalid, go to DONE with access_err=1; ReadData unchanged.
REQ-033 A gnt/rvalid arriving in the same cycle as the timeout SHALL win: normal completion, no error.
REQ-034 Loads use the byte lane selected by addr[1:0] and the half lane selected by addr[1].
REQ-035 Load extension: LB 000 sign-extends the byte; LH 001 sign-extends the half; LW 010 passes the word; LBU 100 and LHU 101 zero-extend.
REQ-036 Store byte enables: SB 000 gives be = 0001 << addr[1:0]; SH 001 gives 0011 or 1100 by addr[1]; SW 010 gives 1111.
REQ-037 Store data: SB replicates wdata[7:0] in all 4 lanes; SH replicates wdata[15:0] in both halves.
REQ-038 ReadData SHALL hold its value until the next successful load; stores and errors do not modify it.
REQ-039 bus_rvalid outside WAIT and bus_gnt outside REQ SHALL be ignored.

Reset
REQ-040 rst_n low SHALL immediately force IDLE and zero ReadData, the counter and all latched fields, regardless of state, including mid-access.
REQ-041 While rst_n is low, bus_req, done, stall and access_err SHALL be 0.
REQ-042 The first access after rst_n rises SHALL be accepted normally.

Structure
REQ-043 Shared package lsu_pkg: state enum (IDLE/REQ/WAIT/DONE) and funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
REQ-044 Sub-module load_extend (combinational): lane select plus sign/zero extension from bus_rdata, addr[1:0] and funct3.

Verification
REQ-045 LB addr=0x103, bus_rdata=0x80FF_FF00, gnt and rvalid immediate -> done on cycle 3, ReadData=0xFFFF_FF80, stall high cycles 0-2.
REQ-046 SH addr=0x202, wdata=0x1234_ABCD -> bus_addr=0x200, bus_be=1100, bus_wdata=0xABCD_ABCD, done on cycle 2, ReadData unchanged.
REQ-047 LW addr=0x101 -> access_err=1 and done=1 in cycle 0, bus_req never asserted, stall=0.
REQ-048 LW with bus_gnt held low, TIMEOUT=16 -> access_err plus done after 16 REQ cycles, ReadData retains the prior value 0x1111_1111.
REQ-049 LHU addr=0x2, bus_rdata=0xBEEF_0000, rvalid delayed 5 cycles -> ReadData=0x0000_BEEF, stall high until DONE.
REQ-050 rst_n asserted during WAIT -> bus_req/stall/done drop immediately, ReadData=0; the next LW completes with correct data.
